pbit_update: RTL and testbench

- Downstream consumer of the LFSR-based RNG random word: one probabilistic-bit update stage.
- Accepts a signed input current I through a valid/ready handshake and samples the RNG output on the same cycle.
- Computes m = (tanh_q(I) > r_signed) ? +1 : -1 and returns the spin to the interconnect/weight logic through a valid/ready handshake.
- Two-stage pipeline: clamp/sample, then LUT + compare. Holds the most recent spin as persistent state.

---
 rtl/pbit_pkg.sv | 24 ++
 rtl/pbit_update_if.sv | 36 +++
 rtl/pbit_tanh_lut.sv | 29 ++
 rtl/pbit_update.sv | 104 ++++++++++
 tb/tb_pbit_update.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pbit_pkg.sv
// Shared definitions for the p-bit update stage.
// Spin encoding, tanh scale and RNG offset helpers.
package pbit_pkg;

  localparam logic SPIN_POS = 1'b1;
  localparam logic SPIN_NEG = 1'b0;
  localparam int   TANH_MAX = 127;

  // Unsigned RNG word recentred around zero.
  function automatic int rng_offset(int r, int w);
    return r - (1 << (w - 1));
  endfunction

  // round(TANH_MAX * tanh(m / 2^shift)) for m >= 0.
  function automatic int tanh_q_calc(int m, int shift);
    real x;
    real e;
    x = 2.0 * real'(m) / real'(1 << shift);
    if (x > 20.0) return TANH_MAX;
    e = $exp(x);
    return int'(real'(TANH_MAX) * (e - 1.0) / (e + 1.0));
  endfunction

endpackage

// File: rtl/pbit_update_if.sv
// Handshake bundle between the p-bit stage and its neighbours.
// Macro PBIT_FLIP_CNT_EN adds the flip counter signal.
interface pbit_update_if #(
  parameter int I_WIDTH    = 8,
  parameter int RAND_WIDTH = 8
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [I_WIDTH-1:0]    i_cur;
  logic        [RAND_WIDTH-1:0] rand_in;
  logic                         out_valid;
  logic                         out_ready;
  logic                         spin;
  logic                         spin_state;
`ifdef PBIT_FLIP_CNT_EN
  logic [15:0]                  flip_cnt;
`endif

  modport slave (
    input  in_valid, i_cur, rand_in, out_ready,
    output in_ready, out_valid, spin, spin_state
`ifdef PBIT_FLIP_CNT_EN
    , output flip_cnt
`endif
  );

  modport master (
    output in_valid, i_cur, rand_in, out_ready,
    input  in_ready, out_valid, spin, spin_state
`ifdef PBIT_FLIP_CNT_EN
    , input flip_cnt
`endif
  );

endinterface

// File: rtl/pbit_tanh_lut.sv
// Combinational quantised tanh lookup.
// Table holds magnitudes only; sign applied after lookup.
module pbit_tanh_lut
  import pbit_pkg::*;
#(
  parameter int I_WIDTH    = 8,
  parameter int TANH_SHIFT = 5
) (
  input  logic signed [I_WIDTH-1:0] x,
  output logic signed [7:0]         y
);

  localparam int N = 1 << (I_WIDTH - 1);

  logic [6:0]           mag_tbl [N];
  logic [I_WIDTH-2:0]   mag;
  logic signed [7:0]    pos;

  for (genvar g = 0; g < N; g++) begin : g_tbl
    assign mag_tbl[g] = 7'(tanh_q_calc(g, TANH_SHIFT));
  end

  // Input is pre-clamped, so -x always fits.
  assign mag = x[I_WIDTH-1] ? (I_WIDTH-1)'(-x)
                            : (I_WIDTH-1)'(x);
  assign pos = signed'({1'b0, mag_tbl[mag]});
  assign y   = x[I_WIDTH-1] ? -pos : pos;

endmodule

// File: rtl/pbit_update.sv
// Two-stage p-bit update: clamp/sample, then tanh compare.
// Macro PBIT_FLIP_CNT_EN adds a saturating flip counter.
module pbit_update
  import pbit_pkg::*;
#(
  parameter int I_WIDTH    = 8,
  parameter int RAND_WIDTH = 8,
  parameter int TANH_SHIFT = 5
) (
  input logic           clk,
  input logic           rst_n,
  pbit_update_if.slave  bus
);

  localparam int CW = (RAND_WIDTH > 8 ? RAND_WIDTH : 8) + 1;
  localparam logic signed [I_WIDTH-1:0] I_MAX =
    I_WIDTH'((1 << (I_WIDTH - 1)) - 1);
  localparam logic signed [I_WIDTH-1:0] I_LO = -I_MAX;

  logic                         s1_valid;
  logic signed [I_WIDTH-1:0]    i_s1;
  logic signed [RAND_WIDTH-1:0] r_s1;
  logic                         out_valid;
  logic                         spin;
  logic                         spin_state;
  logic                         adv2;
  logic                         in_ready;
  logic                         acc;
  logic                         xfer;
  logic signed [I_WIDTH-1:0]    i_clamp;
  logic signed [RAND_WIDTH-1:0] r_in_s;
  logic signed [7:0]            tanh_q;
  logic                         cmp;

  assign adv2     = !out_valid || bus.out_ready;
  assign in_ready = !s1_valid || adv2;
  assign acc      = bus.in_valid && in_ready;
  assign xfer     = out_valid && bus.out_ready;

  assign i_clamp = (bus.i_cur < I_LO) ? I_LO : bus.i_cur;
  assign r_in_s  = RAND_WIDTH'(
    rng_offset(int'(bus.rand_in), RAND_WIDTH));

  pbit_tanh_lut #(
    .I_WIDTH    (I_WIDTH),
    .TANH_SHIFT (TANH_SHIFT)
  ) u_lut (
    .x (i_s1),
    .y (tanh_q)
  );

  assign cmp = CW'(tanh_q) > CW'(r_s1);

  // Stage 1: capture clamped current and recentred random word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      i_s1     <= '0;
      r_s1     <= '0;
    end else begin
      if (in_ready) s1_valid <= bus.in_valid;
      if (acc) begin
        i_s1 <= i_clamp;
        r_s1 <= r_in_s;
      end
    end
  end

  // Stage 2: register the compare result as the presented spin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      spin      <= SPIN_NEG;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) spin <= cmp ? SPIN_POS : SPIN_NEG;
    end
  end

  // Persistent state follows each consumed spin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spin_state <= SPIN_NEG;
    else if (xfer) spin_state <= spin;
  end

`ifdef PBIT_FLIP_CNT_EN
  logic [15:0] flip_cnt;

  // Count consumed spins that differ from the held state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flip_cnt <= '0;
    else if (xfer && spin != spin_state && flip_cnt != '1)
      flip_cnt <= flip_cnt + 16'd1;
  end

  assign bus.flip_cnt = flip_cnt;
`endif

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.spin       = spin;
  assign bus.spin_state = spin_state;

endmodule

// File: tb/tb_pbit_update.sv
// Directed bench for the p-bit update stage.
// Optional PBIT_FLIP_CNT_EN checks the flip counter.
module tb_pbit_update;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pbit_update_if #(.I_WIDTH(8), .RAND_WIDTH(8)) bus ();

  pbit_update #(
    .I_WIDTH    (8),
    .RAND_WIDTH (8),
    .TANH_SHIFT (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int i;
    int r;
    int e;
  } vec_t;

  int passed = 0;
  int total  = 0;

  int si [256];
  int sr [256];
  int se [256];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Single sample: latency, value, consume, state update.
  task automatic one_vec(int i, int r, int e, string nm);
    @(negedge clk);
    bus.i_cur     = 8'(i);
    bus.rand_in   = 8'(r);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({nm, " lat0"}, int'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk({nm, " ovalid"}, int'(bus.out_valid), 1);
    chk({nm, " spin"}, int'(bus.spin), e);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " state"}, int'(bus.spin_state), e);
    chk({nm, " drop"}, int'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
  endtask

  // Cycle-level streaming driver with occupancy model.
  task automatic run_stream(input int n, input bit bp,
                            output int cyc, output int stalls);
    int  acc_i = 0;
    int  out_i = 0;
    int  infl  = 0;
    bit  hold  = 1'b0;
    int  held  = 0;
    bit  xf;
    bit  ac;
    cyc    = 0;
    stalls = 0;
    while (out_i < n && cyc < 2000) begin
      @(negedge clk);
      bus.out_ready = bp ? (cyc >= 4) : 1'b1;
      if (acc_i < n) begin
        bus.in_valid = 1'b1;
        bus.i_cur    = 8'(si[acc_i]);
        bus.rand_in  = 8'(sr[acc_i]);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (hold) begin
        chk("hold spin", int'(bus.spin), held);
        chk("hold valid", int'(bus.out_valid), 1);
      end
      chk("in_ready", int'(bus.in_ready),
          int'(!(infl == 2 && !bus.out_ready)));
      if (!bus.in_ready) stalls++;
      xf = bus.out_valid && bus.out_ready;
      ac = bus.in_valid && bus.in_ready;
      if (xf) begin
        chk("stream spin", int'(bus.spin), se[out_i]);
        out_i++;
      end
      hold = bus.out_valid && !bus.out_ready;
      held = int'(bus.spin);
      @(posedge clk); #1;
      if (xf)
        chk("stream state", int'(bus.spin_state), se[out_i-1]);
      if (ac) acc_i++;
      infl = infl + int'(ac) - int'(xf);
      cyc++;
    end
    if (out_i < n)
      chk("stream timeout", out_i, n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t vt [12];
    int   iv [8];
    int   tq [8];
    int   cyc;
    int   stalls;
    logic [7:0] lfsr;

    vt[0]  = '{0,    'h80, 0};
    vt[1]  = '{127,  'hFE, 1};
    vt[2]  = '{127,  'hFF, 0};
    vt[3]  = '{-128, 'h00, 1};
    vt[4]  = '{-128, 'h01, 0};
    vt[5]  = '{-127, 'h00, 1};
    vt[6]  = '{32,   'hE1, 0};
    vt[7]  = '{32,   'hE0, 1};
    vt[8]  = '{-32,  'h1F, 0};
    vt[9]  = '{-32,  'h1E, 1};
    vt[10] = '{16,   'hBA, 1};
    vt[11] = '{64,   'hFA, 0};

    iv = '{0, 127, -128, 32, -32, 16, 64, 8};
    tq = '{0, 127, -127, 97, -97, 59, 122, 31};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.i_cur     = '0;
    bus.rand_in   = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst spin", int'(bus.spin), 0);
    chk("rst state", int'(bus.spin_state), 0);
    chk("rst in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++)
      one_vec(vt[k].i, vt[k].r, vt[k].e,
              $sformatf("vec%0d", k));

    si[0] = 127;  sr[0] = 'h00; se[0] = 1;
    si[1] = -128; sr[1] = 'hFF; se[1] = 0;
    si[2] = 127;  sr[2] = 'h10; se[2] = 1;
    si[3] = 0;    sr[3] = 'h00; se[3] = 1;
    run_stream(4, 1'b1, cyc, stalls);
    chk("bp stalls", stalls, 2);

    lfsr = 8'h5A;
    for (int k = 0; k < 256; k++) begin
      si[k] = iv[k % 8];
      sr[k] = int'(lfsr);
      se[k] = int'(tq[k % 8] > int'(lfsr) - 128);
      lfsr  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    run_stream(256, 1'b0, cyc, stalls);
    chk("cont cycles", cyc, 258);
    chk("cont stalls", stalls, 0);

    one_vec(127, 'hFE, 1, "pre_rst");
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.i_cur    = 8'(127);
    bus.rand_in  = 8'h00;
    @(posedge clk); #1;
    bus.i_cur   = 8'(-128);
    bus.rand_in = 8'hFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("full valid", int'(bus.out_valid), 1);
    chk("full in_ready", int'(bus.in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", int'(bus.out_valid), 0);
    chk("mid rst spin", int'(bus.spin), 0);
    chk("mid rst state", int'(bus.spin_state), 0);
    chk("mid rst ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    one_vec(0, 'h80, 0, "post_rst");

`ifdef PBIT_FLIP_CNT_EN
    chk("flip reset", int'(bus.flip_cnt), 0);
    one_vec(127,  'h00, 1, "flip0");
    one_vec(-128, 'hFF, 0, "flip1");
    one_vec(0,    'hFF, 0, "flip2");
    one_vec(127,  'h00, 1, "flip3");
    chk("flip count", int'(bus.flip_cnt), 3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
